// File: rtl/dircc_application_pkg.sv
// -----------------------------------------------------------------------------
// dircc_application_pkg
// Heat-diffusion application types: the per-device user state, the
// temperature message and the static per-device properties held in the
// thread context table.
// -----------------------------------------------------------------------------
package dircc_application_pkg;

   // 64-bit user state of one heat cell.
   typedef struct packed {
      logic [15:0] t;
      logic [15:0] accNow;
      logic [7:0]  seenNow;
      logic [15:0] accNext;
      logic [7:0]  seenNext;
   } dev_state_t;

   // Outgoing temperature message, packed into the low bits of a packet.
   typedef struct packed {
      logic        isDesignatedPacket;
      logic [15:0] t;
      logic [15:0] temp;
      logic [31:0] source;
      logic [31:0] count;
   } temp_msg_t;

   // Static properties of one device.
   typedef struct packed {
      logic [15:0] maxTime;
      logic [7:0]  neighbourCount;
      logic        isSender;
   } dev_properties_t;

   // Thread context table: four threads of two devices each, selected by
   // the low thread-address bits and the device index.
   function automatic dev_properties_t dircc_thread_contexts(input logic [1:0] thread,
                                                             input logic       device);
      dev_properties_t p;
      case ({thread, device})
         3'b00_0: p = '{maxTime: 16'd1000,  neighbourCount: 8'd4, isSender: 1'b1};
         3'b00_1: p = '{maxTime: 16'd50,    neighbourCount: 8'd4, isSender: 1'b0};
         3'b01_0: p = '{maxTime: 16'd6,     neighbourCount: 8'd4, isSender: 1'b0};
         3'b01_1: p = '{maxTime: 16'd7,     neighbourCount: 8'd3, isSender: 1'b1};
         3'b10_0: p = '{maxTime: 16'd20,    neighbourCount: 8'd2, isSender: 1'b1};
         3'b10_1: p = '{maxTime: 16'd12,    neighbourCount: 8'd4, isSender: 1'b0};
         3'b11_0: p = '{maxTime: 16'd0,     neighbourCount: 8'd4, isSender: 1'b1};
         default: p = '{maxTime: 16'hFFFF,  neighbourCount: 8'd4, isSender: 1'b0};
      endcase
      return p;
   endfunction

endpackage

// File: rtl/dircc_system_states_pkg.sv
// -----------------------------------------------------------------------------
// dircc_system_states_pkg
// System-level device run-state flags, shared by every DiRCC handler.
// A device that carries the DONE or STOPPED flag has finished its run and
// must not emit any more packets.
// -----------------------------------------------------------------------------
package dircc_system_states_pkg;

   localparam logic [7:0] DIRCC_STATE_DONE    = 8'h01;
   localparam logic [7:0] DIRCC_STATE_STOPPED = 8'h02;

   // Any of these flags means the device has halted.
   localparam logic [7:0] DIRCC_STATE_HALTED_MASK = DIRCC_STATE_DONE | DIRCC_STATE_STOPPED;

endpackage

// File: rtl/dircc_types_pkg.sv
// -----------------------------------------------------------------------------
// dircc_types_pkg
// Generic thread-level types: the per-device state record held in state
// memory, the raw packet container and the send-handler FSM encoding.
// -----------------------------------------------------------------------------
package dircc_types_pkg;

   // Device state word as stored in state memory. user_state carries the
   // application-specific record (dev_state_t for the heat application).
   typedef struct packed {
      logic [7:0]  dircc_state;
      logic [23:0] dircc_state_extra;
      logic [63:0] user_state;
   } device_state_t;

   // Raw fabric payload; application messages occupy the low bits.
   localparam int unsigned PACKET_WIDTH = 128;
   typedef logic [PACKET_WIDTH-1:0] packet_data_t;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_EVAL   = 2'd1,
      S_SEND   = 2'd2,
      S_COMMIT = 2'd3
   } send_fsm_state_t;

endpackage

// File: rtl/dircc_gals_send_handler.sv
// -----------------------------------------------------------------------------
// dircc_gals_send_handler
// Transmit-side handler for one heat-diffusion device. On a send-slot grant
// it checks whether all neighbour contributions for the current timestep
// have arrived; if so it emits one temp_msg_t packet over a valid/ready
// handshake and then commits the advanced device state.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   address              thread address (context index and packet source)
//   send_request         single-cycle send-slot grant
//   busy                 high while the FSM is not idle
//   read_state           current device state from state memory
//   packet_out(_valid)   outgoing packet and its valid flag
//   packet_out_ready     fabric accepts the packet
//   send_done            one-cycle completion pulse
//   send_skipped         qualifies send_done: no packet was sent
//   write_state(_valid)  updated device state and its write strobe
// -----------------------------------------------------------------------------
module dircc_gals_send_handler
   import dircc_system_states_pkg::*;
   import dircc_types_pkg::*;
   import dircc_application_pkg::*;
#(
   parameter int unsigned ADDRESS_MEM_WIDTH = 32,
   parameter              NODE_TYPE         = "default",
   parameter int unsigned DEVICE_ID         = 0
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [ADDRESS_MEM_WIDTH-1:0] address,
   input  logic                         send_request,
   output logic                         busy,
   input  device_state_t                read_state,
   output packet_data_t                 packet_out,
   output logic                         packet_out_valid,
   input  logic                         packet_out_ready,
   output logic                         send_done,
   output logic                         send_skipped,
   output device_state_t                write_state,
   output logic                         write_state_valid
);

   // NODE_TYPE is a descriptive tag only; an empty tag changes nothing.
   if ($bits(NODE_TYPE) == 0) begin : g_untagged_node
   end

   localparam logic DEVICE_SEL = DEVICE_ID[0];

   send_fsm_state_t state;
   logic [31:0]     cycle_count;

   dev_state_t      old_dev;
   dev_state_t      new_dev;
   dev_properties_t props;
   temp_msg_t       msg;
   device_state_t   next_state;
   logic [15:0]     t_next;
   logic            halted;
   logic            all_seen;

   // Packet contents and the state update, derived from the current state.
   always_comb begin
      // NOTE: every variable gets a value before any conditional use, so no latch can be inferred.
      old_dev  = dev_state_t'(read_state.user_state);
      props    = dircc_thread_contexts(address[1:0], DEVICE_SEL);
      t_next   = old_dev.t + 16'd1;
      halted   = (read_state.dircc_state & DIRCC_STATE_HALTED_MASK) != 8'd0;
      all_seen = (old_dev.seenNow == props.neighbourCount);

      msg.isDesignatedPacket = props.isSender;
      msg.t                  = t_next;
      msg.temp               = old_dev.accNow;
      msg.source             = 32'(address);
      msg.count              = cycle_count;

      // Accumulators move forward one slot; the next-step slot starts empty.
      new_dev.t        = t_next;
      new_dev.accNow   = old_dev.accNext;
      new_dev.seenNow  = old_dev.seenNext;
      new_dev.accNext  = 16'd0;
      new_dev.seenNext = 8'd0;

      next_state.dircc_state       = read_state.dircc_state;
      next_state.dircc_state_extra = read_state.dircc_state_extra;
      next_state.user_state        = 64'(new_dev);
      if (t_next == props.maxTime) begin
         next_state.dircc_state = DIRCC_STATE_DONE | DIRCC_STATE_STOPPED;
      end
   end

   // Free-running cycle counter stamped into every packet; wraps.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count <= 32'd0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so all registers update together.
         cycle_count <= cycle_count + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the packet and write data are reset too, so outputs are defined zeros after reset.
         state             <= S_IDLE;
         packet_out        <= '0;
         packet_out_valid  <= 1'b0;
         send_done         <= 1'b0;
         send_skipped      <= 1'b0;
         write_state       <= '0;
         write_state_valid <= 1'b0;
      end else begin
         send_done         <= 1'b0;
         send_skipped      <= 1'b0;
         write_state_valid <= 1'b0;

         unique case (state)
            S_IDLE: begin
               if (send_request) begin
                  if (halted) begin
                     // Finished devices answer at once without sending.
                     send_done    <= 1'b1;
                     send_skipped <= 1'b1;
                  end else begin
                     state <= S_EVAL;
                  end
               end
            end

            S_EVAL: begin
               if (all_seen) begin
                  packet_out       <= PACKET_WIDTH'(msg);
                  packet_out_valid <= 1'b1;
                  write_state      <= next_state;
                  state            <= S_SEND;
               end else begin
                  send_done    <= 1'b1;
                  send_skipped <= 1'b1;
                  state        <= S_IDLE;
               end
            end

            S_SEND: begin
               // packet_out is held untouched until the fabric takes it.
               if (packet_out_valid && packet_out_ready) begin
                  packet_out_valid  <= 1'b0;
                  write_state_valid <= 1'b1;
                  send_done         <= 1'b1;
                  state             <= S_COMMIT;
               end
            end

            S_COMMIT: begin
               state <= S_IDLE;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: doc/dircc_gals_send_handler.md
# dircc_gals_send_handler

Per-device transmit-side handler for the DiRCC GALS heat-diffusion application; it is the sending counterpart of the per-device receive handler. When the thread scheduler grants a send slot, it checks whether the device has collected all neighbour contributions for its current timestep. If so, it builds one outgoing `temp_msg_t` packet, hands it to the fabric over a valid/ready handshake, and commits the advanced device state back to state memory. It sits between the device state store and the thread's packet output port, one instance per device.

## Interface
Parameters:
- `ADDRESS_MEM_WIDTH`, 32, width of the thread address used to index `dircc_thread_contexts`.
- `NODE_TYPE`, "default", device type tag; no behavioural effect in this block.
- `DEVICE_ID`, 0, device index within the thread context.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: sole clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `address` input `ADDRESS_MEM_WIDTH`: thread address, stable while not idle.
- `send_request` input 1: single-cycle send-slot grant from the scheduler.
- `busy` output 1: high whenever the FSM is not in IDLE.
- `read_state` input `device_state_t`: current device state; `user_state[63:0]` is `dev_state_t`.
- `packet_out` output `packet_data_t`: outgoing packet (`temp_msg_t` layout).
- `packet_out_valid` output 1: packet present.
- `packet_out_ready` input 1: fabric accepts the packet.
- `send_done` output 1: one-cycle pulse when the request completes (sent, skipped or finished).
- `send_skipped` output 1: qualifies `send_done`; set when no packet was sent.
- `write_state` output `device_state_t`: updated state.
- `write_state_valid` output 1: one-cycle write strobe.

## Operation
- FSM states and transitions:
  - IDLE: `send_request` moves to EVAL. A request is ignored when `read_state.dircc_state` has the DONE or STOPPED bit set; `send_done=1` and `send_skipped=1` are still pulsed in the next cycle.
  - EVAL: registers the decision, then moves to one of:
    - If `seenNow == neighbourCount` (all neighbour contributions collected): go to SEND.
    - Otherwise: go to IDLE with `send_done=1` and `send_skipped=1`; no state write.
  - SEND: holds `packet_out_valid` high until `packet_out_valid && packet_out_ready`, then moves to COMMIT.
  - COMMIT: pulses `write_state_valid`, `send_done` and `send_skipped=0` for one cycle, then returns to IDLE.
- Packet fields, latched in EVAL and held stable throughout SEND:
  - `t = old.t + 1` (16-bit, wraps modulo 2^16).
  - `temp = old.accNow`.
  - `source = address`.
  - `count` = the free-running 32-bit cycle counter, which wraps.
  - `isDesignatedPacket = properties.isSender`.
- State update written in COMMIT:
  - `t` takes `old.t + 1`; `accNow` takes `old.accNext`; `seenNow` takes `old.seenNext`.
  - `accNext` and `seenNext` are cleared to 0.
  - `dircc_state_extra` passes through unchanged.
  - If `old.t + 1 == properties.maxTime`, `dircc_state` takes `DIRCC_STATE_DONE | DIRCC_STATE_STOPPED`; otherwise it is passed through.
- Arithmetic:
  - Accumulator fields are copied, never re-summed; weights are applied on the receive side.
  - Counters do not saturate.

## Timing
- Reset: all outputs are 0, the FSM is in IDLE, and the cycle counter is 0.
- Request sampled at edge N:
  - EVAL at N+1.
  - `packet_out_valid` from N+2.
  - Acceptance at edge M ≥ N+2.
  - `write_state_valid` and `send_done` high during cycle M+1.
- Minimum request-to-done latency is 3 cycles; the skip path takes 2 cycles.
- `send_request` while busy is dropped, not queued.
- `packet_out` must not change while valid and not yet accepted.
- `packet_out_valid` never deasserts without acceptance, except on reset.
- Reset mid-SEND: the packet is abandoned and no state write occurs. After reset the device re-sends on its next grant because its state is unchanged.
- `read_state` must not change between EVAL and COMMIT; the receive handler is exclusive with this block by scheduler arbitration.

## Structure
- `temp_msg_t`, `dev_state_t` and the DIRCC_STATE_* constants live in `dircc_application_pkg` and `dircc_system_states_pkg`.
- Add `send_fsm_state_t` (IDLE/EVAL/SEND/COMMIT) to `dircc_types_pkg`.
- No sub-module; the cycle counter is inline.

## Test plan
- Default stimulus for every scenario: t=5, seenNow=neighbourCount=4, accNow=100, seenNext=2, accNext=30, `packet_out_ready` tied to 1, unless stated otherwise.
- Baseline send: request → packet t=6, temp=100, source=`address`; state write t=6, seenNow=2, accNow=30, seenNext=0, accNext=0; `send_done` 3 cycles after the request.
- Not ready: seenNow=3 → no `packet_out_valid`; `send_done=1`, `send_skipped=1` 2 cycles after the request; no `write_state_valid`.
- Backpressure: `packet_out_ready` held low for 5 cycles → `packet_out` stable and valid throughout; commit occurs exactly 1 cycle after `packet_out_ready` rises.
- Finish: t=maxTime-1 → packet sent; write has `dircc_state` = DONE|STOPPED; a later request is skipped with no packet.
- Reset and busy: assert `reset_n=0` during SEND → `packet_out_valid` is 0 immediately and no write occurs. Separately, a second `send_request` during SEND is ignored, giving exactly one `send_done`.
